// File: rtl/symbol_timestamp_fifo.sv
// Sample counter that timestamps OFDM symbol starts into a small show-ahead FIFO.
// Optional macro SAMPLE_ID_CLEAR_EN adds the sample_id_clear_i counter-clear port.
module symbol_timestamp_fifo #(
    parameter int unsigned SAMPLE_ID_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         s_axis_in_tvalid,
    input  logic                         sym_start_i,
`ifdef SAMPLE_ID_CLEAR_EN
    input  logic                         sample_id_clear_i,
`endif
    output logic [SAMPLE_ID_WIDTH-1:0]   sample_id_data,
    output logic                         sample_id_valid,
    input  logic                         sample_id_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fill_o,
    output logic                         overflow_o
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    logic [SAMPLE_ID_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [SAMPLE_ID_WIDTH-1:0] cnt_q;
    logic [SAMPLE_ID_WIDTH-1:0] cnt_d;
    logic [SAMPLE_ID_WIDTH-1:0] id_c;
    logic [SAMPLE_ID_WIDTH-1:0] head_d;
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_d;
    logic [PTR_W-1:0]           wr_ptr_d;
    logic [FILL_W-1:0]          fill_rem;
    logic [FILL_W-1:0]          fill_d;
    logic                       push_req;
    logic                       pop;
    logic                       full;
    logic                       push_ok;
    logic                       drop;

    // ID of the current sample and the counter value after it
    always_comb begin
        id_c = cnt_q;
`ifdef SAMPLE_ID_CLEAR_EN
        if (sample_id_clear_i) begin
            id_c = '0;
        end
`endif
        cnt_d = id_c;
        if (s_axis_in_tvalid) begin
            cnt_d = id_c + SAMPLE_ID_WIDTH'(1);
        end
    end

    // FIFO bookkeeping; a pop on a full FIFO makes room for the same-cycle push
    always_comb begin
        push_req = s_axis_in_tvalid & sym_start_i;
        pop      = sample_id_valid & sample_id_ready;
        full     = (fill_o == FILL_W'(FIFO_DEPTH));
        push_ok  = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        fill_rem = fill_o - FILL_W'(pop);
        fill_d   = fill_rem + FILL_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    end

    // Next head: freshly pushed entry if nothing else remains, else stored entry; hold when empty
    always_comb begin
        head_d = sample_id_data;
        if (fill_d != '0) begin
            if (fill_rem == '0) begin
                head_d = id_c;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end
    end

    // Storage array; reset only clears the pointers that give it meaning
    always_ff @(posedge clk_i) begin
        if (reset_ni && push_ok) begin
            mem[wr_ptr_q] <= id_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            cnt_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            fill_o          <= '0;
            sample_id_valid <= 1'b0;
            sample_id_data  <= '0;
            overflow_o      <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            fill_o          <= fill_d;
            sample_id_valid <= (fill_d != '0);
            sample_id_data  <= head_d;
            overflow_o      <= drop;
        end
    end

endmodule

// File: doc/symbol_timestamp_fifo.md
SYMBOL_TIMESTAMP_FIFO -- requirements
Module: symbol_timestamp_fifo

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- SAMPLE_ID_WIDTH, 64, sample counter / timestamp width.
- FIFO_DEPTH, 4, timestamp entries; power of two, at least 2.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i, in, 1, single clock; all logic on its rising edge.
- reset_ni, in, 1, synchronous active-low reset.
- s_axis_in_tvalid, in, 1, one received time-domain sample this cycle.
- sym_start_i, in, 1, current sample is the first sample of an OFDM symbol; qualified by s_axis_in_tvalid.
- sample_id_data, out, SAMPLE_ID_WIDTH, FIFO head timestamp.
- sample_id_valid, out, 1, FIFO not empty.
- sample_id_ready, in, 1, consumer pops the head.
- fill_o, out, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- overflow_o, out, 1, one-cycle pulse when a timestamp is dropped.
- sample_id_clear_i, in, 1, counter clear; present only with SAMPLE_ID_CLEAR_EN.

Function
REQ-003 Sample counter SHALL increment by 1 on every cycle with s_axis_in_tvalid=1 and hold otherwise.
REQ-004 Counter SHALL wrap from 2^SAMPLE_ID_WIDTH-1 to 0 with no flag.
REQ-005 On s_axis_in_tvalid=1 and sym_start_i=1, the pre-increment counter value (ID of that sample) SHALL be pushed.
REQ-006 sym_start_i with s_axis_in_tvalid=0 SHALL be ignored.
REQ-007 FIFO SHALL be show-ahead:
- sample_id_data equals the head entry whenever sample_id_valid=1.
- sample_id_data holds its last value when empty.
REQ-008 Pop SHALL occur on sample_id_valid=1 and sample_id_ready=1; sample_id_ready while empty SHALL be ignored.
REQ-009 A push SHALL make sample_id_valid=1 on the next cycle (one-cycle push-to-valid latency); an empty FIFO SHALL NOT bypass the entry to the output in the push cycle.
REQ-010 Simultaneous push and pop SHALL both take effect; fill_o stays unchanged.
REQ-011 Full FIFO behaviour:
- Simultaneous pop frees space, so the push SHALL succeed.
- Push without pop SHALL drop the new entry; existing entries unchanged.
- overflow_o SHALL be 1 on the cycle after the drop, 0 otherwise.
REQ-012 fill_o SHALL be registered and exact every cycle, range 0..FIFO_DEPTH.
REQ-013 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or by fill_o.
REQ-014 Ordering SHALL be strictly FIFO; no entry is duplicated or reordered.

Reset
REQ-015 While reset_ni=0 at a clock edge:
- counter, pointers and fill_o SHALL be 0.
- sample_id_valid=0, overflow_o=0, sample_id_data=0.
REQ-016 Reset asserted mid-operation SHALL discard all stored entries.
REQ-017 Inputs in the reset cycle SHALL be ignored; the first sample after release SHALL get ID 0.

Configuration
REQ-018 Macro SAMPLE_ID_CLEAR_EN defined SHALL add port sample_id_clear_i:
- clear=1 with s_axis_in_tvalid=0: counter becomes 0 next cycle.
- clear=1 with s_axis_in_tvalid=1: that sample's ID is 0 (pushed as 0 if sym_start_i=1); counter becomes 1.
- FIFO contents unaffected.
REQ-019 Macro undefined SHALL remove the port; the counter clears only on reset.

Verification
REQ-020 Reset release, then 10 samples with sym_start_i on samples 0 and 7 -> FIFO holds 0 then 7; fill_o=2; sample_id_valid rises the cycle after sample 0.
REQ-021 FIFO_DEPTH=4, 5 symbol starts, no pops -> entries 4 stored; 5th dropped; overflow_o pulses once; fill_o=4; order intact on drain.
REQ-022 Full FIFO, push and pop in the same cycle -> head popped, new entry stored, fill_o stays 4, overflow_o=0.
REQ-023 Counter preloaded to 2^64-2 via stimulus run length (or forced), 3 samples with sym_start_i on each -> IDs 2^64-2, 2^64-1, 0.
REQ-024 With SAMPLE_ID_CLEAR_EN: counter=500, clear+tvalid+sym_start_i -> entry 0 pushed; next sample ID 1.
REQ-025 Reset asserted with fill_o=3 -> valid=0, fill_o=0; next sym_start sample pushes 0.
